// File: rtl/alu_issuer.sv
// rtl/alu_issuer.sv - in-order single-outstanding ALU command issuer with 4-deep command queue
// Commands are queued as {op, B, A}. They issue one at a time, and each response is tagged with its issue index mod 4.

module alu_issuer_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_tvalid,
    output logic        in_tready,
    input  logic [10:0] in_tdata,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic [10:0] out_tdata,
    output logic [2:0]  level
);
    logic [10:0] mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        do_push;
    logic        do_pop;

    // in_tready comes only from the registered count, so a same-cycle pop cannot make room
    assign in_tready  = (count != 3'd4);
    assign out_tvalid = (count != 3'd0);
    assign out_tdata  = mem[rd_ptr];
    assign level      = count;
    assign do_push    = in_tvalid && in_tready;
    assign do_pop     = out_tvalid && out_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 2'd1;
            if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= in_tdata;
    end
endmodule

module alu_issuer #(
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic [2:0] cmd_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_tag,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] LAT = 3'(ALU_LAT);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  wait_cnt;
    logic        q_valid;
    logic [10:0] q_data;
    logic [2:0]  q_level;
    logic        pop;
    logic        load_wait;
    logic        dec_wait;
    logic        capture;
    logic        release_rsp;

    alu_issuer_fifo u_cmd_q (
        .clk        (clk),
        .rst        (rst),
        .in_tvalid  (cmd_valid),
        .in_tready  (cmd_ready),
        .in_tdata   ({cmd_op, cmd_data}),
        .out_tvalid (q_valid),
        .out_tready (pop),
        .out_tdata  (q_data),
        .level      (q_level)
    );

    assign busy = (state != IDLE) || (q_level != 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        load_wait   = 1'b0;
        dec_wait    = 1'b0;
        capture     = 1'b0;
        release_rsp = 1'b0;
        case (state)
            IDLE: begin
                if (q_valid) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                load_wait = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_cnt == 3'd1) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    dec_wait = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    release_rsp = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // alu_* change only on a pop, so the ALU sees stable operands for the whole WAIT window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a     <= 4'd0;
            alu_b     <= 4'd0;
            alu_op    <= 3'd0;
            wait_cnt  <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'd0;
            rsp_tag   <= 2'd0;
        end else begin
            if (pop) begin
                alu_a  <= q_data[3:0];
                alu_b  <= q_data[7:4];
                alu_op <= q_data[10:8];
            end
            if (load_wait)     wait_cnt <= LAT;
            else if (dec_wait) wait_cnt <= wait_cnt - 3'd1;
            if (capture) begin
                rsp_data  <= alu_result;
                rsp_valid <= 1'b1;
            end else if (release_rsp) begin
                rsp_valid <= 1'b0;
                rsp_tag   <= rsp_tag + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_alu_issuer.sv
// tb/tb_alu_issuer.sv - scoreboard bench for alu_issuer with a registered 1-cycle ALU model
module tb_alu_issuer;
    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic [2:0] cmd_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result = 8'd0;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] rsp_tag;
    logic       busy;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [9:0] sb [$];
    logic [1:0] exp_tag = 2'd0;
    int         seen;

    alu_issuer #(.ALU_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        case (alu_op)
            3'b000:  alu_result <= {4'd0, alu_a} + {4'd0, alu_b};
            3'b001:  alu_result <= {4'd0, alu_a} - {4'd0, alu_b};
            default: alu_result <= {4'd0, alu_a & alu_b};
        endcase
    end

    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst && rsp_valid && rsp_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_unexpected: actual data=%02h tag=%0d, required no response", rsp_data, rsp_tag);
            end else begin
                e = sb.pop_front();
                if (rsp_data !== e[7:0] || rsp_tag !== e[9:8]) begin
                    n_bad++;
                    $display("FAIL rsp_compare: actual data=%02h tag=%0d, required data=%02h tag=%0d",
                             rsp_data, rsp_tag, e[7:0], e[9:8]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // leaves cmd_valid high so consecutive calls push back-to-back
    task automatic push(input logic [7:0] d, input logic [2:0] op, input logic [7:0] exp);
        logic acc;
        acc       = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_op    = op;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
        end
        if (acc) begin
            sb.push_back({exp_tag, exp});
            exp_tag = exp_tag + 2'd1;
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: actual cmd_ready=0 for 50 cycles, required accept of %02h", d);
        end
    endtask

    task automatic wait_idle(input int max);
        logic done;
        done = 1'b0;
        for (int n = 0; n < max && !done; n++) begin
            @(posedge clk);
            #1;
            if (!busy) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: actual busy=1 after %0d cycles, required busy=0", max);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'd0;
        cmd_op    = 3'd0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_alu", {alu_op, alu_b, alu_a}, 0);
        chk("reset_rsp", {rsp_tag, rsp_data}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // first push right after reset, with latency checks
        cmd_valid = 1'b1;
        cmd_data  = 8'h35;
        cmd_op    = 3'b000;
        @(negedge clk);
        chk("ready_after_reset", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        sb.push_back({2'd0, 8'h08});
        exp_tag = 2'd1;
        chk("busy_after_push", busy, 1);
        @(posedge clk);
        #1;
        chk("lat_alu_a", alu_a, 5);
        chk("lat_alu_b", alu_b, 3);
        chk("lat_alu_op", alu_op, 0);
        chk("lat_rsp_n1", rsp_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_rsp_n2", rsp_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_rsp_n3", rsp_valid, 1);
        chk("lat_rsp_data", rsp_data, 8'h08);
        chk("lat_rsp_tag", rsp_tag, 0);
        wait_idle(20);

        // sequential ops, subtract, tag wrap
        push(8'h53, 3'b001, 8'hFE); cmd_valid = 1'b0; wait_idle(20);
        push(8'hFF, 3'b000, 8'h1E); cmd_valid = 1'b0; wait_idle(20);
        push(8'h7A, 3'b001, 8'h03); cmd_valid = 1'b0; wait_idle(20);
        push(8'h21, 3'b001, 8'hFF); cmd_valid = 1'b0; wait_idle(20);
        chk("seq_drain", sb.size(), 0);

        // full queue plus response backpressure
        rsp_ready = 1'b0;
        push(8'h12, 3'b000, 8'h03);
        push(8'h34, 3'b000, 8'h07);
        push(8'h56, 3'b001, 8'h01);
        push(8'h11, 3'b000, 8'h02);
        push(8'h9C, 3'b001, 8'h03);
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("full_cmd_ready", cmd_ready, 0);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 8'h03);
            chk("bp_rsp_tag", rsp_tag, 1);
            chk("bp_alu", {alu_op, alu_b, alu_a}, {3'b000, 4'h1, 4'h2});
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        wait_idle(60);
        chk("full_drain", sb.size(), 0);

        // reset while in WAIT with two commands queued
        rsp_ready = 1'b0;
        push(8'h35, 3'b000, 8'h08);
        push(8'h53, 3'b001, 8'hFE);
        push(8'h12, 3'b000, 8'h03);
        cmd_valid = 1'b0;
        chk("pre_reset_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_alu_a", alu_a, 0);
        sb.delete();
        exp_tag = 2'd0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("no_stale_rsp", seen, 0);
        @(posedge clk);
        #1;
        push(8'h53, 3'b001, 8'hFE);
        cmd_valid = 1'b0;
        wait_idle(20);
        chk("post_reset_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1);
    end
endmodule
